// File: rtl/tmr_time_redundant_alu_sequencer.sv
// Time-redundant ALU controller: runs each operation three times on one shared ALU,
// votes the captures, retries the triple on no-majority, and reports fault status.

module generic_ternary_voter_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [31:0] y,
  output logic        error_detected,
  output logic        invalid_output
);
  always_comb begin
    y              = a;
    error_detected = 1'b0;
    invalid_output = 1'b0;
    if (a == b && b == c) begin
      y = a;
    end else if (a == b || a == c) begin
      y              = a;
      error_detected = 1'b1;
    end else if (b == c) begin
      y              = b;
      error_detected = 1'b1;
    end else begin
      error_detected = 1'b1;
      invalid_output = 1'b1;
    end
  end
endmodule

module tmr_time_redundant_alu_sequencer #(
  parameter int ALU_LAT   = 1,
  parameter int MAX_RETRY = 2,
  parameter int RW        = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [4:0]    req_opcode,
  input  logic [31:0]   req_a,
  input  logic [31:0]   req_b,
  output logic [4:0]    alu_opcode,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic          alu_start,
  input  logic [31:0]   alu_result,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_result,
  output logic          resp_corrected,
  output logic          resp_fail,
  output logic [RW-1:0] resp_retries,
  output logic [15:0]   err_count,
  output logic [15:0]   fail_count
);
  localparam int WW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_VOTE, S_RESP} state_t;

  state_t        state;
  logic [1:0]    k;
  logic [RW-1:0] retries;
  logic [WW-1:0] wcnt;
  logic [31:0]   cap_a, cap_b, cap_c;
  logic [31:0]   vote_y;
  logic          vote_err, vote_inv;

  generic_ternary_voter_32bit u_voter (
    .a              (cap_a),
    .b              (cap_b),
    .c              (cap_c),
    .y              (vote_y),
    .error_detected (vote_err),
    .invalid_output (vote_inv)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      k              <= '0;
      retries        <= '0;
      wcnt           <= '0;
      cap_a          <= '0;
      cap_b          <= '0;
      cap_c          <= '0;
      req_ready      <= 1'b1;
      alu_opcode     <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_start      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_result    <= '0;
      resp_corrected <= 1'b0;
      resp_fail      <= 1'b0;
      resp_retries   <= '0;
      err_count      <= '0;
      fail_count     <= '0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            alu_opcode <= req_opcode;
            alu_a      <= req_a;
            alu_b      <= req_b;
            k          <= '0;
            retries    <= '0;
            req_ready  <= 1'b0;
            alu_start  <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == WW'(ALU_LAT - 1)) begin
            case (k)
              2'd0:    cap_a <= alu_result;
              2'd1:    cap_b <= alu_result;
              default: cap_c <= alu_result;
            endcase
            if (k != 2'd2) begin
              k         <= k + 2'd1;
              alu_start <= 1'b1;
              state     <= S_START;
            end else begin
              state <= S_VOTE;
            end
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        S_VOTE: begin
          // alu_start is raised on the transition so it is high exactly in START
          if (vote_inv && retries < RW'(MAX_RETRY)) begin
            retries   <= retries + RW'(1);
            k         <= '0;
            alu_start <= 1'b1;
            state     <= S_START;
          end else begin
            resp_valid     <= 1'b1;
            resp_result    <= vote_y;
            resp_corrected <= vote_err & ~vote_inv;
            resp_fail      <= vote_inv;
            resp_retries   <= retries;
            if (vote_err && !vote_inv && err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
            if (vote_inv && fail_count != 16'hFFFF)
              fail_count <= fail_count + 16'd1;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tmr_time_redundant_alu_sequencer.sv
// Bench for tmr_time_redundant_alu_sequencer: directed vector table, hold/reset
// sequences, and randomized fault injection against a triple-vote reference model.

module tb_tmr_time_redundant_alu_sequencer;
  localparam int L  = 1;
  localparam int MR = 2;
  localparam int RW = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [4:0]    req_opcode = '0;
  logic [31:0]   req_a = '0, req_b = '0;
  logic [4:0]    alu_opcode;
  logic [31:0]   alu_a, alu_b;
  logic          alu_start;
  logic [31:0]   alu_result = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_result;
  logic          resp_corrected, resp_fail;
  logic [RW-1:0] resp_retries;
  logic [15:0]   err_count, fail_count;

  tmr_time_redundant_alu_sequencer #(.ALU_LAT(L), .MAX_RETRY(MR), .RW(RW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_corrected(resp_corrected), .resp_fail(resp_fail), .resp_retries(resp_retries),
    .err_count(err_count), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] masks [9];
  int          run_idx = 0;
  int          start_cyc [$];
  logic [15:0] m_err = '0, m_fail = '0;

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, b);
    case (op)
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  // Shared ALU: result valid from the cycle after each start pulse, faulted per run.
  always @(negedge clock) begin
    if (alu_start) begin
      start_cyc.push_back(cyc);
      alu_result = alu_fn(alu_opcode, alu_a, alu_b) ^ ((run_idx < 9) ? masks[run_idx] : 32'd0);
      run_idx = run_idx + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic run_txn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit chk_res, input logic [31:0] er, input logic ec,
                         input logic ef, input logic [1:0] eret, input int elat,
                         input logic [15:0] eerr, input logic [15:0] efc, input bit hold);
    int t;
    int tr;
    bit got;
    logic [31:0] snap;
    t = 0;
    tr = 0;
    start_cyc.delete();
    run_idx = 0;
    @(negedge clock);
    req_opcode = op; req_a = a; req_b = b; req_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (req_ready) begin got = 1; t = cyc; end
      else @(negedge clock);
    end
    if (!got) begin chk("accept_timeout", 32'd0, 32'd1); req_valid = 1'b0; return; end
    @(posedge clock); #1 req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      if (resp_valid) begin got = 1; tr = cyc; end
    end
    if (!got) begin chk("resp_timeout", 32'd0, 32'd1); return; end
    chk("latency", 32'(tr - t), 32'(elat));
    chk("start_count", 32'(start_cyc.size()), 32'(3 * (eret + 1)));
    foreach (start_cyc[r])
      chk("start_cycle", 32'(start_cyc[r] - t), 32'(1 + r * (L + 1) + r / 3));
    if (chk_res) chk("result", resp_result, er);
    chk("corrected", 32'(resp_corrected), 32'(ec));
    chk("fail", 32'(resp_fail), 32'(ef));
    chk("retries", 32'(resp_retries), 32'(eret));
    chk("err_count", 32'(err_count), 32'(eerr));
    chk("fail_count", 32'(fail_count), 32'(efc));
    chk("alu_a_held", alu_a, a);
    chk("alu_opcode_held", 32'(alu_opcode), 32'(op));
    if (hold) begin
      snap = resp_result;
      for (int i = 0; i < 5; i++) begin
        req_valid = (i < 2);
        req_a = 32'hDEAD0000 + 32'(i);
        @(negedge clock);
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_result", resp_result, snap);
        chk("hold_req_ready", 32'(req_ready), 32'd0);
        chk("hold_no_start", 32'(alu_start), 32'd0);
      end
      req_valid = 1'b0;
      chk("hold_start_count", 32'(start_cyc.size()), 32'(3 * (eret + 1)));
    end
    resp_ready = 1'b1;
    @(posedge clock); #1 resp_ready = 1'b0;
    @(negedge clock);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  // Reference: vote each triple in order; first with a majority wins, else fail.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic corr, output logic fl,
                       output logic [1:0] ret, output int lat);
    logic [31:0] g, v0, v1, v2;
    bit found;
    g = alu_fn(op, a, b);
    found = 0; res = '0; corr = 0; fl = 1; ret = 2'(MR);
    for (int t = 0; t <= MR && !found; t++) begin
      v0 = g ^ masks[3*t]; v1 = g ^ masks[3*t+1]; v2 = g ^ masks[3*t+2];
      if (v0 == v1 || v0 == v2 || v1 == v2) begin
        found = 1; fl = 0; ret = 2'(t);
        res = (v0 == v1 || v0 == v2) ? v0 : v1;
        corr = !(v0 == v1 && v1 == v2);
      end
    end
    lat = 3 * (L + 1) + 2 + int'(ret) * (3 * (L + 1) + 1);
    if (corr && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    if (fl && m_fail != 16'hFFFF) m_fail = m_fail + 16'd1;
  endtask

  typedef struct {
    logic [4:0]       op;
    logic [31:0]      a, b;
    logic [8:0][31:0] m;
    logic [31:0]      res;
    logic             corr, fail;
    logic [1:0]       ret;
    int               lat;
    logic [15:0]      errc, failc;
    bit               chk_res;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int t;
    bit got;
    logic [4:0]  op;
    logic [31:0] a, b, er;
    logic        ec, ef;
    logic [1:0]  eret;
    int          elat;

    vecs[0] = '{op:5'd0, a:32'd5, b:32'd7, m:'0, res:32'd12, corr:1'b0, fail:1'b0,
                ret:2'd0, lat:8, errc:16'd0, failc:16'd0, chk_res:1'b1};
    vecs[1] = vecs[0]; vecs[1].m[1] = 32'd1; vecs[1].corr = 1'b1; vecs[1].errc = 16'd1;
    vecs[2] = vecs[1]; vecs[2].m[2] = 32'd2; vecs[2].corr = 1'b0;
    vecs[2].ret = 2'd1; vecs[2].lat = 15;
    vecs[3] = vecs[2];
    for (int r = 3; r < 9; r++) vecs[3].m[r] = 32'(r % 3);
    vecs[3].fail = 1'b1; vecs[3].ret = 2'd2; vecs[3].lat = 22;
    vecs[3].failc = 16'd1; vecs[3].chk_res = 1'b0;
    for (int r = 0; r < 9; r++) masks[r] = '0;

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clock); reset_n = 1'b1;

    foreach (vecs[i]) begin
      for (int r = 0; r < 9; r++) masks[r] = vecs[i].m[r];
      run_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chk_res, vecs[i].res, vecs[i].corr,
              vecs[i].fail, vecs[i].ret, vecs[i].lat, vecs[i].errc, vecs[i].failc, 1'b0);
    end
    m_err = 16'd1; m_fail = 16'd1;

    for (int r = 0; r < 9; r++) masks[r] = '0;
    run_txn(5'd0, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 1'b0, 2'd0, 8, m_err, m_fail, 1'b1);

    // Reset asserted during the second WAIT cycle.
    start_cyc.delete(); run_idx = 0;
    @(negedge clock);
    req_opcode = 5'd1; req_a = 32'd40; req_b = 32'd2; req_valid = 1'b1;
    got = 0; t = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (req_ready) begin got = 1; t = cyc; end
      else @(negedge clock);
    end
    @(posedge clock); #1 req_valid = 1'b0;
    for (int i = 0; i < 20 && cyc < t + 4; i++) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("arst_alu_start", 32'(alu_start), 32'd0);
    chk("arst_alu_a", alu_a, 32'd0);
    chk("arst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_fail_count", 32'(fail_count), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    m_err = '0; m_fail = '0;
    @(negedge clock);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    run_txn(5'd0, 32'd100, 32'd23, 1'b1, 32'd123, 1'b0, 1'b0, 2'd0, 8, 16'd0, 16'd0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 6));
      a = $urandom; b = $urandom;
      for (int r = 0; r < 9; r++)
        masks[r] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 2)) : 32'd0;
      model(op, a, b, er, ec, ef, eret, elat);
      run_txn(op, a, b, !ef, er, ec, ef, eret, elat, m_err, m_fail, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
